// File: rtl/usb_rx_deframer.sv
// USB host receive deframer: NRZI decode, SYNC hunt, bit unstuffing and EOP detection.
// Define USB_RX_BYTE_PACK_EN to pack the unstuffed bits LSB-first into bytes.
module usb_rx_deframer #(
  parameter int STUFF_LIMIT  = 6,
  parameter int MAX_PKT_BITS = 1024,
  parameter int IDLE_J_BITS  = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       DP,
  input  logic       DM,
  output logic       bit_out,
  output logic       bit_valid,
  output logic       pkt_start,
  output logic       pkt_end,
  output logic       err_sync,
  output logic       err_stuff,
  output logic       err_eop,
  output logic       err_len,
  output logic       busy,
  output logic [7:0] byte_out,
  output logic       byte_valid,
  output logic       err_align
);

  localparam int OW = $clog2(STUFF_LIMIT + 1);
  localparam int BW = $clog2(MAX_PKT_BITS + 1);
  localparam int JW = $clog2(IDLE_J_BITS + 1);
  localparam logic [OW-1:0] STUFF_MAX = OW'(STUFF_LIMIT);
  localparam logic [BW-1:0] BITS_MAX  = BW'(MAX_PKT_BITS);
  localparam logic [JW-1:0] J_LAST    = JW'(IDLE_J_BITS - 1);

  typedef enum logic [2:0] {
    ST_IDLE, ST_SYNC, ST_DATA, ST_EOP1, ST_EOP2, ST_ERR
  } state_t;

  state_t          state;
  logic            prev_j;
  logic [6:0]      sync_sr;
  logic [2:0]      sync_cnt;
  logic [OW-1:0]   ones_cnt;
  logic [BW-1:0]   bit_cnt;
  logic [JW-1:0]   j_cnt;

  logic is_j, is_k, is_se0, is_se1, dec_bit;

  assign is_j    = DP & ~DM;
  assign is_k    = ~DP & DM;
  assign is_se0  = ~DP & ~DM;
  assign is_se1  = DP & DM;
  // NRZI: an unchanged J/K level is a 1, a transition is a 0
  assign dec_bit = (is_j & prev_j) | (is_k & ~prev_j);

  assign busy = (state != ST_IDLE);

`ifdef USB_RX_BYTE_PACK_EN
  logic [2:0] pack_cnt;
  logic [7:0] pack_sr;
`else
  assign byte_out   = 8'h00;
  assign byte_valid = 1'b0;
  assign err_align  = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      prev_j    <= 1'b1;
      sync_cnt  <= '0;
      ones_cnt  <= '0;
      bit_cnt   <= '0;
      j_cnt     <= '0;
      bit_out   <= 1'b0;
      bit_valid <= 1'b0;
      pkt_start <= 1'b0;
      pkt_end   <= 1'b0;
      err_sync  <= 1'b0;
      err_stuff <= 1'b0;
      err_eop   <= 1'b0;
      err_len   <= 1'b0;
`ifdef USB_RX_BYTE_PACK_EN
      pack_cnt   <= '0;
      byte_out   <= 8'h00;
      byte_valid <= 1'b0;
      err_align  <= 1'b0;
`endif
    end else begin
      bit_valid <= 1'b0;
      pkt_start <= 1'b0;
      pkt_end   <= 1'b0;
      err_sync  <= 1'b0;
      err_stuff <= 1'b0;
      err_eop   <= 1'b0;
      err_len   <= 1'b0;
      j_cnt     <= '0;
`ifdef USB_RX_BYTE_PACK_EN
      byte_valid <= 1'b0;
      err_align  <= 1'b0;
`endif
      if (is_j | is_k) prev_j <= is_j;

      case (state)
        ST_IDLE: begin
          if (is_k) begin
            state    <= ST_SYNC;
            sync_sr  <= '0;
            sync_cnt <= 3'd1;
          end
        end
        ST_SYNC: begin
          if (is_se0 | is_se1) begin
            err_sync <= 1'b1;
            state    <= ST_ERR;
          end else if (sync_cnt == 3'd7) begin
            // SYNC is seven decoded 0s followed by a single 1
            if (sync_sr == '0 && dec_bit) begin
              pkt_start <= 1'b1;
              ones_cnt  <= OW'(1);
              bit_cnt   <= '0;
              state     <= ST_DATA;
`ifdef USB_RX_BYTE_PACK_EN
              pack_cnt  <= '0;
`endif
            end else begin
              err_sync <= 1'b1;
              state    <= ST_ERR;
            end
          end else begin
            sync_sr  <= {dec_bit, sync_sr[6:1]};
            sync_cnt <= sync_cnt + 3'd1;
          end
        end
        ST_DATA: begin
          if (is_se0) begin
            state <= ST_EOP1;
          end else if (is_se1) begin
            err_eop <= 1'b1;
            state   <= ST_ERR;
          end else if (ones_cnt == STUFF_MAX) begin
            if (dec_bit) begin
              err_stuff <= 1'b1;
              state     <= ST_ERR;
            end else begin
              ones_cnt <= '0;
            end
          end else if (bit_cnt == BITS_MAX) begin
            err_len <= 1'b1;
            state   <= ST_ERR;
          end else begin
            bit_valid <= 1'b1;
            bit_out   <= dec_bit;
            bit_cnt   <= bit_cnt + BW'(1);
            ones_cnt  <= dec_bit ? ones_cnt + OW'(1) : '0;
`ifdef USB_RX_BYTE_PACK_EN
            pack_sr  <= {dec_bit, pack_sr[7:1]};
            pack_cnt <= pack_cnt + 3'd1;
            if (pack_cnt == 3'd7) begin
              byte_out   <= {dec_bit, pack_sr[7:1]};
              byte_valid <= 1'b1;
            end
`endif
          end
        end
        ST_EOP1: begin
          if (is_se0) begin
            state <= ST_EOP2;
          end else begin
            err_eop <= 1'b1;
            state   <= ST_ERR;
          end
        end
        ST_EOP2: begin
          if (is_j) begin
            pkt_end <= 1'b1;
            prev_j  <= 1'b1;
            state   <= ST_IDLE;
`ifdef USB_RX_BYTE_PACK_EN
            err_align <= (bit_cnt[2:0] != 3'd0);
`endif
          end else begin
            err_eop <= 1'b1;
            state   <= ST_ERR;
          end
        end
        ST_ERR: begin
          // leave only after an unbroken run of J (idle) samples
          if (is_j) begin
            if (j_cnt == J_LAST) begin
              state  <= ST_IDLE;
              prev_j <= 1'b1;
            end else begin
              j_cnt <= j_cnt + JW'(1);
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_usb_rx_deframer.sv
// Scoreboard bench for usb_rx_deframer: packets are encoded at bit level and the expected output events queued.
module tb_usb_rx_deframer;

  localparam int MAXB   = 1024;
  localparam int IDLE_J = 8;
`ifdef USB_RX_BYTE_PACK_EN
  localparam bit PACK = 1'b1;
`else
  localparam bit PACK = 1'b0;
`endif

  typedef logic [17:0] ev_t;
  localparam ev_t EV_START = 18'h20000;
  localparam ev_t EV_BV    = 18'h10000;
  localparam ev_t EV_BO    = 18'h08000;
  localparam ev_t EV_END   = 18'h04000;
  localparam ev_t EV_SYNC  = 18'h02000;
  localparam ev_t EV_STUFF = 18'h01000;
  localparam ev_t EV_EOP   = 18'h00800;
  localparam ev_t EV_LEN   = 18'h00400;
  localparam ev_t EV_ALIGN = 18'h00200;
  localparam ev_t EV_BYV   = 18'h00100;

  logic clk = 1'b0;
  logic rst, DP, DM;
  logic bit_out, bit_valid, pkt_start, pkt_end;
  logic err_sync, err_stuff, err_eop, err_len, busy;
  logic [7:0] byte_out;
  logic byte_valid, err_align;

  always #5 clk = ~clk;

  usb_rx_deframer #(.STUFF_LIMIT(6), .MAX_PKT_BITS(MAXB), .IDLE_J_BITS(IDLE_J)) dut (
    .clk(clk), .rst(rst), .DP(DP), .DM(DM),
    .bit_out(bit_out), .bit_valid(bit_valid), .pkt_start(pkt_start), .pkt_end(pkt_end),
    .err_sync(err_sync), .err_stuff(err_stuff), .err_eop(err_eop), .err_len(err_len),
    .busy(busy), .byte_out(byte_out), .byte_valid(byte_valid), .err_align(err_align)
  );

  ev_t exp_q[$];
  bit  dq[$];
  int  checks = 0;
  int  errors = 0;
  bit  lvl_j;
  int  run, nbits, pcnt;
  logic [7:0] pbyte;

  // Monitor: every cycle that carries an output event is matched against the queue head.
  always @(negedge clk) begin
    ev_t act, expv;
    act = {pkt_start, bit_valid, bit_valid & bit_out, pkt_end, err_sync, err_stuff,
           err_eop, err_len, err_align, byte_valid, (byte_valid ? byte_out : 8'h00)};
    if (act[17:8] != 10'd0) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL event act=%h exp=none t=%0t", act, $time);
      end else begin
        expv = exp_q.pop_front();
        if (act !== expv) begin
          errors++;
          $display("FAIL event act=%h exp=%h t=%0t", act, expv, $time);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", name, act, expv);
    end
  endtask

  function automatic void push(input ev_t e);
    exp_q.push_back(e);
  endfunction

  task automatic drive(input logic dp, input logic dm);
    DP = dp;
    DM = dm;
    @(posedge clk);
    #1;
  endtask

  task automatic nrzi(input bit b);
    if (!b) lvl_j = !lvl_j;
    drive(lvl_j, !lvl_j);
  endtask

  task automatic push_byte(input logic [7:0] v);
    for (int i = 0; i < 8; i++) dq.push_back(v[i]);
  endtask

  task automatic gap();
    int n;
    n = $urandom_range(1, 3);
    for (int i = 0; i < n; i++) begin
      if ($urandom % 5 == 0) drive(1'b0, 1'b0);
      else drive(1'b1, 1'b0);
    end
    drive(1'b1, 1'b0);
    lvl_j = 1'b1;
  endtask

  task automatic send_sync();
    push(EV_START);
    for (int i = 0; i < 7; i++) nrzi(1'b0);
    nrzi(1'b1);
    run = 1; nbits = 0; pcnt = 0; pbyte = 8'h00;
  endtask

  // Stuff a 0 after six 1s, then emit the bit; the (MAXB+1)th bit must raise err_len.
  task automatic send_bit(input bit b);
    ev_t e;
    if (run == 6) begin
      nrzi(1'b0);
      run = 0;
    end
    if (nbits == MAXB) begin
      push(EV_LEN);
    end else begin
      pbyte[pcnt] = b;
      e = EV_BV | (b ? EV_BO : 18'h0);
      if (PACK && pcnt == 7) e = e | EV_BYV | ev_t'(pbyte);
      push(e);
      nbits++;
      pcnt = (pcnt + 1) % 8;
    end
    nrzi(b);
    run = b ? run + 1 : 0;
  endtask

  task automatic send_eop(input bit omit_stuff);
    if (run == 6 && !omit_stuff) nrzi(1'b0);
    push(EV_END | ((PACK && (nbits % 8 != 0)) ? EV_ALIGN : 18'h0));
    drive(1'b0, 1'b0);
    drive(1'b0, 1'b0);
    drive(1'b1, 1'b0);
    lvl_j = 1'b1;
    run = 0;
  endtask

  task automatic good_pkt(input bit omit_stuff);
    gap();
    send_sync();
    foreach (dq[i]) send_bit(dq[i]);
    send_eop(omit_stuff);
  endtask

  task automatic rand_data(input int len);
    dq.delete();
    for (int i = 0; i < len; i++) dq.push_back($urandom % 4 != 0);
  endtask

  task automatic to_idle(input int n);
    for (int i = 0; i < n; i++) begin
      int r;
      r = $urandom % 4;
      drive(r[1], r[0]);
    end
    repeat (IDLE_J) drive(1'b1, 1'b0);
    lvl_j = 1'b1;
    run = 0;
  endtask

  task automatic stuff_err(input int k);
    send_sync();
    for (int i = 0; i < k; i++) send_bit($urandom % 4 != 0);
    while (run < 6) send_bit(1'b1);
    push(EV_STUFF);
    nrzi(1'b1);
  endtask

  task automatic eop_err();
    int v, k;
    logic [1:0] tail;
    gap();
    send_sync();
    k = $urandom_range(0, 20);
    for (int i = 0; i < k; i++) send_bit($urandom % 4 != 0);
    v = $urandom % 3;
    push(EV_EOP);
    if (v == 0) begin
      drive(1'b1, 1'b1);
    end else if (v == 1) begin
      drive(1'b0, 1'b0);
      tail = ($urandom % 3 == 0) ? 2'b10 : (($urandom % 2 == 0) ? 2'b01 : 2'b11);
      drive(tail[1], tail[0]);
    end else begin
      drive(1'b0, 1'b0);
      drive(1'b0, 1'b0);
      tail = ($urandom % 3 == 0) ? 2'b01 : (($urandom % 2 == 0) ? 2'b00 : 2'b11);
      drive(tail[1], tail[0]);
    end
    to_idle($urandom_range(0, 5));
  endtask

  task automatic sync_err_rand();
    logic [1:0] lv [8];
    logic [1:0] prev;
    int err_at;
    bit b, nz;
    lv[0] = 2'b01;
    for (int i = 1; i < 8; i++) begin
      int r;
      r = $urandom % 8;
      lv[i] = (r == 0) ? 2'b00 : (r == 1) ? 2'b11 : (r < 5) ? 2'b10 : 2'b01;
    end
    prev = 2'b10; err_at = 7; nz = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (lv[i] == 2'b00 || lv[i] == 2'b11) begin
        err_at = i;
        break;
      end
      b = (lv[i] == prev);
      prev = lv[i];
      if (i < 7 && b) nz = 1'b1;
      if (i == 7 && !nz && b) lv[7] = ~lv[7];
    end
    gap();
    push(EV_SYNC);
    for (int i = 0; i <= err_at; i++) drive(lv[i][1], lv[i][0]);
    to_idle($urandom_range(0, 5));
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_flags"}, {23'd0, bit_valid, pkt_start, pkt_end, err_sync, err_stuff,
                          err_eop, err_len, byte_valid, err_align}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_bit_out"}, {31'd0, bit_out}, 32'd0);
    chk({tag, "_byte_out"}, {24'd0, byte_out}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; DP = 1'b1; DM = 1'b0;
    lvl_j = 1'b1; run = 0; nbits = 0; pcnt = 0; pbyte = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk_quiet("reset");
    rst = 1'b0;
    repeat (4) drive(1'b1, 1'b0);

    // ACK PID
    dq.delete(); push_byte(8'hD2); good_pkt(1'b0);
    // FF forces a stuffed 0, then 00
    dq.delete(); push_byte(8'hFF); push_byte(8'h00); good_pkt(1'b0);

    // stuffing violation, then busy until the 8th idle J
    gap();
    stuff_err(0);
    repeat (IDLE_J - 1) drive(1'b1, 1'b0);
    chk("busy_in_err", {31'd0, busy}, 32'd1);
    drive(1'b1, 1'b0);
    chk("busy_after_idle_j", {31'd0, busy}, 32'd0);
    lvl_j = 1'b1; run = 0;

    // KJKJKJKJ is not SYNC; next packet must still decode
    gap();
    push(EV_SYNC);
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 0) drive(1'b0, 1'b1);
      else drive(1'b1, 1'b0);
    end
    to_idle(0);
    rand_data(24); good_pkt(1'b0);

    // PID C3 followed by a truncated EOP
    gap();
    send_sync();
    dq.delete(); push_byte(8'hC3);
    foreach (dq[i]) send_bit(dq[i]);
    push(EV_EOP);
    drive(1'b0, 1'b0);
    drive(1'b1, 1'b0);
    to_idle(0);

    // 12-bit packet: partial byte at EOP
    rand_data(12); good_pkt(1'b0);
    // five data 1s with SE0 in the pending stuff slot
    dq.delete(); repeat (5) dq.push_back(1'b1); good_pkt(1'b1);
    // exactly the maximum length is accepted
    rand_data(MAXB); good_pkt(1'b0);
    // one bit beyond the maximum
    gap();
    send_sync();
    for (int i = 0; i <= MAXB; i++) send_bit($urandom % 4 != 0);
    to_idle(0);

    // reset in the middle of a DATA0 packet
    gap();
    send_sync();
    dq.delete(); push_byte(8'hC3);
    foreach (dq[i]) send_bit(dq[i]);
    for (int i = 0; i < 5; i++) send_bit($urandom % 2 == 0);
    rst = 1'b1; DP = 1'b1; DM = 1'b0;
    @(posedge clk);
    #1;
    chk_quiet("mid_reset");
    rst = 1'b0; lvl_j = 1'b1; run = 0;
    dq.delete(); push_byte(8'hC3); push_byte(8'hA5); push_byte(8'h3C); good_pkt(1'b0);

    for (int it = 0; it < 60; it++) begin
      case ($urandom % 6)
        0, 1, 2: begin rand_data($urandom_range(0, 48)); good_pkt($urandom % 2 == 0); end
        3: begin gap(); stuff_err($urandom_range(0, 16)); to_idle($urandom_range(0, 5)); end
        4: eop_err();
        default: sync_err_rand();
      endcase
    end

    repeat (20) drive(1'b1, 1'b0);
    chk("queue_drained", exp_q.size(), 32'd0);
    chk("idle_at_end", {31'd0, busy}, 32'd0);
`ifndef USB_RX_BYTE_PACK_EN
    chk("byte_out_zero", {24'd0, byte_out}, 32'd0);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
